// File: rtl/seg_scan_scheduler.sv
// seg_scan_scheduler: time-multiplexes one seven-segment decoder across
// NUM_DIGITS common-anode digits. Each digit gets BLANK_CYCLES of dead-time
// (all anodes off, nibble pre-settled) followed by DWELL_CYCLES on. New
// digit values enter a shadow register via valid/ready and are committed to
// the active set only at the frame boundary (end of the last digit's dwell).
// Optional feature macro: SEG_BRIGHTNESS_EN adds a 3-bit brightness input
// that shortens the lit part of each dwell in eighths.
module seg_scan_scheduler #(
  parameter int unsigned NUM_DIGITS   = 2,
  parameter int unsigned DWELL_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4*NUM_DIGITS-1:0]       digit_vals,
  input  logic                          load_valid,
`ifdef SEG_BRIGHTNESS_EN
  input  logic [2:0]                    brightness,
`endif
  output logic                          load_ready,
  output logic [3:0]                    dec_nibble,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_start
);

  localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned IW      = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_ON    = 1'b1;

  logic [0:0]              state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [IW-1:0]           idx_n;
  logic [4*NUM_DIGITS-1:0] active, active_n;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_n;
  logic                    pending, pending_n;
  logic                    boundary;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   anode_n;
  logic [3:0]              nibble_n;
  logic                    frame_start_n;

`ifdef SEG_BRIGHTNESS_EN
  logic [2:0]  bright_q, bright_n;
  logic [31:0] lit_limit;
`endif

  // Next-state logic; outputs are derived from next-state values so the
  // registered outputs line up with the state they describe.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    idx_n     = digit_idx;
    boundary  = 1'b0;
    if (state == ST_BLANK) begin
      if (cnt == BLANK_LAST) begin
        state_n = ST_ON;
        cnt_n   = '0;
      end
    end else begin
      if (cnt == DWELL_LAST) begin
        state_n  = ST_BLANK;
        cnt_n    = '0;
        boundary = (digit_idx == IDX_LAST);
        idx_n    = (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      end
    end

    // Commit at the frame boundary; an accept on the same edge (only possible
    // when nothing is pending) lands in shadow and waits a full frame.
    active_n  = (boundary && pending) ? shadow : active;
    pending_n = (boundary && pending) ? 1'b0 : pending;
    shadow_n  = shadow;
    if (load_valid && !pending) begin
      shadow_n  = digit_vals;
      pending_n = 1'b1;
    end

    frame_start_n = (state == ST_BLANK) && (state_n == ST_ON) && (digit_idx == '0);

`ifdef SEG_BRIGHTNESS_EN
    bright_n  = frame_start_n ? brightness : bright_q;
    lit_limit = ((32'(bright_n) + 32'd1) * DWELL_CYCLES) / 32'd8;
    lit       = (32'(cnt_n) < lit_limit);
`else
    lit       = 1'b1;
`endif

    anode_n  = '1;
    nibble_n = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_n == IW'(i)) begin
        nibble_n = active_n[4*i +: 4];
        if (state_n == ST_ON && lit) anode_n[i] = 1'b0;
      end
    end
  end

  // State, data and registered output update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_BLANK;
      cnt         <= '0;
      digit_idx   <= '0;
      active      <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
      anode       <= '1;
      dec_nibble  <= '0;
      load_ready  <= 1'b1;
      frame_start <= 1'b0;
`ifdef SEG_BRIGHTNESS_EN
      bright_q    <= '0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      digit_idx   <= idx_n;
      active      <= active_n;
      shadow      <= shadow_n;
      pending     <= pending_n;
      anode       <= anode_n;
      dec_nibble  <= nibble_n;
      load_ready  <= ~pending_n;
      frame_start <= frame_start_n;
`ifdef SEG_BRIGHTNESS_EN
      bright_q    <= bright_n;
`endif
    end
  end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Directed bench for seg_scan_scheduler: 2-digit and 4-digit instances with
// short dwell/blank periods, checking scan order, nibble pre-settle, frame
// commit timing, handshake back-pressure and mid-operation reset.
module tb_seg_scan_scheduler;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 2-digit instance
  logic        rst2;
  logic [7:0]  dv2;
  logic        lv2;
  logic        rdy2;
  logic [3:0]  nib2;
  logic [1:0]  anode2;
  logic [0:0]  idx2;
  logic        fs2;

  // 4-digit instance
  logic        rst4;
  logic [15:0] dv4;
  logic        lv4;
  logic        rdy4;
  logic [3:0]  nib4;
  logic [3:0]  anode4;
  logic [1:0]  idx4;
  logic        fs4;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  seg_scan_scheduler #(.NUM_DIGITS(2), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) u2 (
    .clk(clk), .reset(rst2), .digit_vals(dv2), .load_valid(lv2),
`ifdef SEG_BRIGHTNESS_EN
    .brightness(3'd7),
`endif
    .load_ready(rdy2), .dec_nibble(nib2), .anode(anode2), .digit_idx(idx2),
    .frame_start(fs2)
  );

  seg_scan_scheduler #(.NUM_DIGITS(4), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) u4 (
    .clk(clk), .reset(rst4), .digit_vals(dv4), .load_valid(lv4),
`ifdef SEG_BRIGHTNESS_EN
    .brightness(3'd7),
`endif
    .load_ready(rdy4), .dec_nibble(nib4), .anode(anode4), .digit_idx(idx4),
    .frame_start(fs4)
  );

`ifdef SEG_BRIGHTNESS_EN
  logic        rstb;
  logic [2:0]  brt;
  logic        rdyb;
  logic [3:0]  nibb;
  logic [1:0]  anodeb;
  logic [0:0]  idxb;
  logic        fsb;

  seg_scan_scheduler #(.NUM_DIGITS(2), .DWELL_CYCLES(8), .BLANK_CYCLES(2)) ub (
    .clk(clk), .reset(rstb), .digit_vals(8'h00), .load_valid(1'b0),
    .brightness(brt),
    .load_ready(rdyb), .dec_nibble(nibb), .anode(anodeb), .digit_idx(idxb),
    .frame_start(fsb)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance to the next cycle (sampled at negedge, mid-cycle); the anode
  // buses must never have more than one digit lit.
  task automatic next_cycle();
    @(negedge clk);
    cyc++;
    chk("one_anode2", 32'($countones(~anode2) <= 1), 32'd1);
    chk("one_anode4", 32'($countones(~anode4) <= 1), 32'd1);
  endtask

  task automatic goto(input int c);
    while (cyc < c) next_cycle();
  endtask

  initial begin
    int nfs;
    rst2 = 1'b0; dv2 = '0; lv2 = 1'b0;
    rst4 = 1'b0; dv4 = '0; lv4 = 1'b0;
`ifdef SEG_BRIGHTNESS_EN
    rstb = 1'b0; brt = 3'd0;
`endif

    // Reset state
    repeat (5) next_cycle();
    chk("rst_anode", 32'(anode2), 32'h3);
    chk("rst_nib", 32'(nib2), 32'h0);
    chk("rst_ready", 32'(rdy2), 32'h1);
    chk("rst_fs", 32'(fs2), 32'h0);
    chk("rst_idx", 32'(idx2), 32'h0);

    // Release and load 5A in cycle 0
    cyc = 0; rst2 = 1'b1; dv2 = 8'h5A; lv2 = 1'b1;
    goto(1);  chk("ready_drop", 32'(rdy2), 32'h0); lv2 = 1'b0;
    goto(2);  chk("d0_anode", 32'(anode2), 32'h2); chk("d0_fs", 32'(fs2), 32'h1);
              chk("d0_nib_old", 32'(nib2), 32'h0);
    goto(3);  chk("fs_pulse", 32'(fs2), 32'h0); chk("busy3", 32'(rdy2), 32'h0);
              dv2 = 8'h33; lv2 = 1'b1;  // must be ignored
    goto(4);  lv2 = 1'b0;
    goto(5);  chk("d0_anode_end", 32'(anode2), 32'h2);
    goto(6);  chk("blank_anode", 32'(anode2), 32'h3); chk("blank_idx", 32'(idx2), 32'h1);
    goto(7);  chk("blank_anode2", 32'(anode2), 32'h3);
    goto(8);  chk("d1_anode", 32'(anode2), 32'h1); chk("d1_nib_old", 32'(nib2), 32'h0);
    goto(11); chk("d1_anode_end", 32'(anode2), 32'h1); chk("busy11", 32'(rdy2), 32'h0);
    goto(12); chk("ready_back", 32'(rdy2), 32'h1); chk("presettle", 32'(nib2), 32'hA);
              chk("presettle_anode", 32'(anode2), 32'h3);
              dv2 = 8'h33; lv2 = 1'b1;  // retry
    goto(13); chk("retry_taken", 32'(rdy2), 32'h0); lv2 = 1'b0;
    goto(14); chk("f2_d0", 32'(nib2), 32'hA); chk("f2_d0_anode", 32'(anode2), 32'h2);
              chk("f2_fs", 32'(fs2), 32'h1);
    goto(17); chk("f2_d0_end", 32'(nib2), 32'hA);
    goto(20); chk("f2_d1", 32'(nib2), 32'h5); chk("f2_d1_anode", 32'(anode2), 32'h1);
    goto(23); chk("f2_d1_end", 32'(nib2), 32'h5);
    goto(24); chk("ready24", 32'(rdy2), 32'h1);
    goto(26); chk("f3_d0", 32'(nib2), 32'h3); chk("f3_fs", 32'(fs2), 32'h1);
    goto(32); chk("f3_d1", 32'(nib2), 32'h3);

    // Accept on the frame-boundary edge with nothing pending
    goto(35); chk("bnd_ready", 32'(rdy2), 32'h1); dv2 = 8'h96; lv2 = 1'b1;
    goto(36); chk("bnd_taken", 32'(rdy2), 32'h0); lv2 = 1'b0;
    goto(38); chk("f4_d0_old", 32'(nib2), 32'h3);
    goto(44); chk("f4_d1_old", 32'(nib2), 32'h3);
    goto(50); chk("f5_d0", 32'(nib2), 32'h6); chk("f5_d0_anode", 32'(anode2), 32'h2);
    goto(56); chk("f5_d1", 32'(nib2), 32'h9); chk("f5_d1_anode", 32'(anode2), 32'h1);

    // Reset during ON of digit 1 with pending data
    goto(62); dv2 = 8'hC7; lv2 = 1'b1;
    goto(63); chk("c7_taken", 32'(rdy2), 32'h0); lv2 = 1'b0;
    goto(68); chk("f6_d1", 32'(nib2), 32'h9); chk("f6_d1_anode", 32'(anode2), 32'h1);
    goto(69); rst2 = 1'b0;
    goto(70); chk("mid_rst_anode", 32'(anode2), 32'h3); chk("mid_rst_nib", 32'(nib2), 32'h0);
              chk("mid_rst_ready", 32'(rdy2), 32'h1); chk("mid_rst_idx", 32'(idx2), 32'h0);
    cyc = 0; rst2 = 1'b1;
    goto(2);  chk("post_d0", 32'(nib2), 32'h0); chk("post_fs", 32'(fs2), 32'h1);
    goto(8);  chk("post_d1", 32'(nib2), 32'h0);
    goto(14); chk("post_f2_d0", 32'(nib2), 32'h0); chk("post_ready", 32'(rdy2), 32'h1);

    // Four digits
    cyc = 0; rst4 = 1'b1; dv4 = 16'h1234; lv4 = 1'b1;
    nfs = 0;
    for (int c = 1; c <= 50; c++) begin
      goto(c);
      if (fs4) nfs++;
      case (c)
        1:  begin chk("q_ready", 32'(rdy4), 32'h0); lv4 = 1'b0; end
        2:  begin chk("q_f1_anode", 32'(anode4), 32'hE); chk("q_f1_nib", 32'(nib4), 32'h0); end
        26: begin chk("q_d0_anode", 32'(anode4), 32'hE); chk("q_d0_nib", 32'(nib4), 32'h4);
                  chk("q_d0_idx", 32'(idx4), 32'h0); end
        32: begin chk("q_d1_anode", 32'(anode4), 32'hD); chk("q_d1_nib", 32'(nib4), 32'h3);
                  chk("q_d1_idx", 32'(idx4), 32'h1); end
        38: begin chk("q_d2_anode", 32'(anode4), 32'hB); chk("q_d2_nib", 32'(nib4), 32'h2);
                  chk("q_d2_idx", 32'(idx4), 32'h2); end
        44: begin chk("q_d3_anode", 32'(anode4), 32'h7); chk("q_d3_nib", 32'(nib4), 32'h1);
                  chk("q_d3_idx", 32'(idx4), 32'h3); end
        50: begin chk("q_wrap_anode", 32'(anode4), 32'hE); chk("q_wrap_nib", 32'(nib4), 32'h4);
                  chk("q_wrap_idx", 32'(idx4), 32'h0); chk("q_wrap_fs", 32'(fs4), 32'h1); end
        default: ;
      endcase
    end
    chk("q_fs_count", 32'(nfs), 32'd3);

`ifdef SEG_BRIGHTNESS_EN
    begin
      int lo0, lo1, lo2;
      lo0 = 0; lo1 = 0; lo2 = 0;
      cyc = 0; rstb = 1'b1; brt = 3'd3;
      for (int c = 1; c <= 29; c++) begin
        goto(c);
        if (c >= 2  && c <= 9  && anodeb == 2'b10) lo0++;
        if (c >= 12 && c <= 19 && anodeb == 2'b01) lo1++;
        if (c >= 22 && c <= 29 && anodeb == 2'b10) lo2++;
        if (c == 5) brt = 3'd7;
      end
      chk("br3_d0", 32'(lo0), 32'd4);
      chk("br3_d1_held", 32'(lo1), 32'd4);
      chk("br7_d0", 32'(lo2), 32'd8);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
